shift_set_monitor: RTL and testbench

Parametrised N-channel single-event-transient (SET) monitor for shift-register chains on the 12nm test die. Drives a static level into each chain's input, synchronises each chain's output into the CLK domain, and counts upset events per channel in saturating counters with sticky overflow flags. A snapshot handshake freezes all counts for readout through a channel-select port. Replaces the single-polarity, two-channel, output-clocked counter.

---
 rtl/shift_mon_pkg.sv | 12 +
 rtl/shift_mon_chan.sv | 72 +++++++
 rtl/shift_set_monitor.sv | 74 +++++++
 tb/tb_shift_set_monitor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shift_mon_pkg.sv
// shift_mon_pkg: shared defaults, reset pattern and saturating increment for the SET monitor.
package shift_mon_pkg;
  localparam int DEF_N_CH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_BLANK_CYC = 64;
  localparam int DEF_PW_W = 8;
  localparam logic RST_PATTERN = 1'b1;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/shift_mon_chan.sv
// shift_mon_chan: one chain's synchroniser, mismatch edge detect, saturating counter, OVF and shadow.
// SHIFT_PULSE_WIDTH_EN adds max-pulse-width tracking; otherwise sh_pw is 0.
module shift_mon_chan import shift_mon_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PW_W = DEF_PW_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shift_out,
  input  logic             pat,
  input  logic             cnt_en,
  input  logic             snap,
  input  logic             clr,
  output logic [CNT_W-1:0] sh_cnt,
  output logic             sh_ovf,
  output logic [PW_W-1:0]  sh_pw
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [SYNC_STAGES-1:0] sync;
  logic mm_q, mm_prev, ev, ovf;
  logic [CNT_W-1:0] cnt;
  assign ev = cnt_en & mm_q & ~mm_prev;
  // mismatch is registered so a counted edge lands SYNC_STAGES+1 edges after first sample
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync <= {SYNC_STAGES{RST_PATTERN}};
      mm_q <= 1'b0;
      mm_prev <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
      sh_cnt <= '0;
      sh_ovf <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], shift_out};
      mm_q <= sync[SYNC_STAGES-1] != pat;
      mm_prev <= mm_q;
      if (snap) begin
        sh_cnt <= cnt;
        sh_ovf <= ovf;
      end
      if (snap & clr) begin
        cnt <= CNT_W'(ev);
        ovf <= 1'b0;
      end else if (ev) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
        ovf <= ovf | (cnt == CNT_MAX);
      end
    end
`ifdef SHIFT_PULSE_WIDTH_EN
  localparam logic [PW_W-1:0] PW_MAX = '1;
  logic [PW_W-1:0] run, pw;
  logic trk;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      run <= '0;
      pw <= '0;
      trk <= 1'b0;
      sh_pw <= '0;
    end else begin
      if (ev) begin
        run <= PW_W'(1);
        trk <= 1'b1;
      end else if (trk & mm_q) run <= PW_W'(sat_inc(32'(run), 32'(PW_MAX)));
      else trk <= 1'b0;
      if (snap) sh_pw <= pw;
      pw <= (snap & clr) ? '0 : (trk && run > pw) ? run : pw;
    end
`else
  assign sh_pw = '0;
`endif
endmodule

// File: rtl/shift_set_monitor.sv
// shift_set_monitor: N-channel SET monitor with blanking, snapshot handshake and channel readout.
// SHIFT_PULSE_WIDTH_EN enables per-channel max pulse width on RD_PW.
module shift_set_monitor import shift_mon_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int PW_W = DEF_PW_W,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             PATTERN,
  input  logic [N_CH-1:0]  SHIFT_OUT,
  output logic [N_CH-1:0]  SHIFT_INPUT,
  input  logic             SNAP_REQ,
  input  logic             SNAP_CLR,
  output logic             SNAP_ACK,
  input  logic [SEL_W-1:0] RD_SEL,
  output logic [CNT_W-1:0] RD_CNT,
  output logic             RD_OVF,
  output logic [PW_W-1:0]  RD_PW,
  output logic             BLANKING
);
  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  logic pat_q, en_q, req_q, snap_d, snap, cnt_en, rd_ok;
  logic [BW-1:0] blank;
  logic [CNT_W-1:0] sh_cnt [N_CH];
  logic [N_CH-1:0] sh_ovf;
  logic [PW_W-1:0] sh_pw [N_CH];
  assign snap = SNAP_REQ & ~req_q;
  assign BLANKING = blank != '0;
  assign cnt_en = ENABLE & ~BLANKING;
  assign SHIFT_INPUT = {N_CH{pat_q}};
  assign rd_ok = 32'(RD_SEL) < N_CH;
  // ACK is delayed one extra cycle so RD_* already reflects the new shadow when it rises
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pat_q <= RST_PATTERN;
      en_q <= 1'b0;
      req_q <= 1'b0;
      snap_d <= 1'b0;
      SNAP_ACK <= 1'b0;
      blank <= '0;
      RD_CNT <= '0;
      RD_OVF <= 1'b0;
      RD_PW <= '0;
    end else begin
      pat_q <= PATTERN;
      en_q <= ENABLE;
      req_q <= SNAP_REQ;
      snap_d <= snap;
      SNAP_ACK <= snap_d;
      blank <= ((ENABLE & ~en_q) | (PATTERN != pat_q)) ? BW'(BLANK_CYC) : BLANKING ? blank - BW'(1) : blank;
      RD_CNT <= rd_ok ? sh_cnt[RD_SEL] : '0;
      RD_OVF <= rd_ok ? sh_ovf[RD_SEL] : 1'b0;
      RD_PW <= rd_ok ? sh_pw[RD_SEL] : '0;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    shift_mon_chan #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .PW_W(PW_W)) u_chan (
      .CLK(CLK),
      .RST(RST),
      .shift_out(SHIFT_OUT[i]),
      .pat(pat_q),
      .cnt_en(cnt_en),
      .snap(snap),
      .clr(SNAP_CLR),
      .sh_cnt(sh_cnt[i]),
      .sh_ovf(sh_ovf[i]),
      .sh_pw(sh_pw[i])
    );
  end
endmodule

// File: tb/tb_shift_set_monitor.sv
// tb_shift_set_monitor: directed bench with an expectation queue filled at snapshot request, drained on readout.
module tb_shift_set_monitor;
  logic CLK = 1'b0, RST = 1'b1, ENABLE = 1'b0, PATTERN = 1'b1, SNAP_REQ = 1'b0, SNAP_CLR = 1'b0;
  logic [3:0] SHIFT_OUT = 4'hF, SHIFT_INPUT;
  logic [1:0] RD_SEL = 2'd0;
  logic [3:0] RD_CNT;
  logic [7:0] RD_PW;
  logic SNAP_ACK, RD_OVF, BLANKING;
  int vectors = 0, miscompares = 0;
  typedef struct {int ch; int cnt; logic ovf; int pw;} exp_t;
  exp_t sb[$];
  int exp_cnt[4], exp_pw[4];
  logic exp_ovf[4];

  shift_set_monitor #(.N_CH(4), .CNT_W(4), .SYNC_STAGES(2), .BLANK_CYC(64), .PW_W(8)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .PATTERN(PATTERN), .SHIFT_OUT(SHIFT_OUT),
    .SHIFT_INPUT(SHIFT_INPUT), .SNAP_REQ(SNAP_REQ), .SNAP_CLR(SNAP_CLR), .SNAP_ACK(SNAP_ACK),
    .RD_SEL(RD_SEL), .RD_CNT(RD_CNT), .RD_OVF(RD_OVF), .RD_PW(RD_PW), .BLANKING(BLANKING)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump(input int c, input int len);
    if (exp_cnt[c] == 15) exp_ovf[c] = 1'b1;
    else exp_cnt[c]++;
    if (len > exp_pw[c]) exp_pw[c] = len;
  endtask

  task automatic pulse(input int c, input int len, input bit counted);
    SHIFT_OUT[c] = ~PATTERN;
    step(len);
    SHIFT_OUT[c] = PATTERN;
    step(5);
    if (counted) bump(c, len);
  endtask

  task automatic do_snap(input logic clr, input int ev_ch);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
`ifdef SHIFT_PULSE_WIDTH_EN
      sb.push_back('{c, exp_cnt[c], exp_ovf[c], exp_pw[c]});
`else
      sb.push_back('{c, exp_cnt[c], exp_ovf[c], 0});
`endif
      if (clr) begin
        exp_cnt[c] = 0;
        exp_ovf[c] = 1'b0;
        exp_pw[c] = 0;
      end
    end
    if (ev_ch >= 0) begin
      SHIFT_OUT[ev_ch] = ~PATTERN;
      step(2);
      SHIFT_OUT[ev_ch] = PATTERN;
      step(1);
      bump(ev_ch, 2);
    end
    SNAP_CLR = clr;
    SNAP_REQ = 1'b1;
    step(1);
    SNAP_REQ = 1'b0;
    SNAP_CLR = 1'b0;
    chk("ack_early", 32'(SNAP_ACK), 0);
    step(1);
    chk("ack", 32'(SNAP_ACK), 1);
    step(1);
    chk("ack_pulse", 32'(SNAP_ACK), 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      RD_SEL = 2'(e.ch);
      step(1);
      chk($sformatf("cnt[%0d]", e.ch), 32'(RD_CNT), 32'(e.cnt));
      chk($sformatf("ovf[%0d]", e.ch), 32'(RD_OVF), 32'(e.ovf));
      chk($sformatf("pw[%0d]", e.ch), 32'(RD_PW), 32'(e.pw));
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      exp_cnt[c] = 0;
      exp_ovf[c] = 1'b0;
      exp_pw[c] = 0;
    end
    step(2);
    chk("rst_shift_input", 32'(SHIFT_INPUT), 32'hF);
    chk("rst_ack", 32'(SNAP_ACK), 0);
    chk("rst_blanking", 32'(BLANKING), 0);
    chk("rst_rd_cnt", 32'(RD_CNT), 0);
    RST = 1'b0;
    ENABLE = 1'b1;
    step(1);
    chk("blank_start", 32'(BLANKING), 1);
    step(63);
    chk("blank_last", 32'(BLANKING), 1);
    step(1);
    chk("blank_end", 32'(BLANKING), 0);
    // three counted low pulses on ch0
    for (int i = 0; i < 3; i++) pulse(0, 2, 1'b1);
    do_snap(1'b0, -1);
    // saturation on ch1
    for (int i = 0; i < 17; i++) pulse(1, 2, 1'b1);
    do_snap(1'b1, -1);
    // event on the same edge as a clearing snapshot
    pulse(0, 2, 1'b1);
    pulse(0, 2, 1'b1);
    do_snap(1'b1, 0);
    do_snap(1'b0, -1);
    // pattern change, chains follow inside the blanking window
    PATTERN = 1'b0;
    step(1);
    chk("pat_blank", 32'(BLANKING), 1);
    chk("pat_shift_input", 32'(SHIFT_INPUT), 0);
    step(9);
    SHIFT_OUT = 4'h0;
    step(54);
    chk("pat_blank_last", 32'(BLANKING), 1);
    step(1);
    chk("pat_blank_end", 32'(BLANKING), 0);
    pulse(2, 2, 1'b1);
    do_snap(1'b1, -1);
    PATTERN = 1'b1;
    SHIFT_OUT = 4'hF;
    step(70);
    // pulse widths on ch3
    pulse(3, 3, 1'b1);
    pulse(3, 7, 1'b1);
    pulse(3, 5, 1'b1);
    do_snap(1'b1, -1);
    chk("pre_rst_cnt", 32'(RD_CNT), 3);
    // reset during blanking and a pending snapshot
    PATTERN = 1'b0;
    step(3);
    SNAP_REQ = 1'b1;
    step(1);
    RST = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(SNAP_ACK), 0);
    chk("mid_rst_cnt", 32'(RD_CNT), 0);
    chk("mid_rst_ovf", 32'(RD_OVF), 0);
    chk("mid_rst_pw", 32'(RD_PW), 0);
    chk("mid_rst_shift_input", 32'(SHIFT_INPUT), 32'hF);
    chk("mid_rst_blanking", 32'(BLANKING), 0);
    step(3);
    RST = 1'b0;
    SNAP_REQ = 1'b0;
    PATTERN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("post_rst_ack", 32'(SNAP_ACK), 0);
    end
    chk("post_rst_cnt", 32'(RD_CNT), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
